// File: rtl/keypad_matrix_emulator.sv
// 4x4 hex keypad responder: holds an accepted key closed for HOLD_CYCLES, then open for GAP_CYCLES.
// Latency: contact closes the cycle after accept; o_Col is combinational from i_Row. Backpressure: o_Ready only in IDLE.
// Optional contact bounce bursts around press/release when KEYPAD_BOUNCE_EN is defined.
module keypad_matrix_emulator #(
    parameter int CNT_W         = 21,
    parameter int HOLD_CYCLES   = 1500000,
    parameter int GAP_CYCLES    = 1500000,
    parameter int BOUNCE_PERIOD = 50000,
    parameter int BOUNCE_NUM    = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Row,
    input  logic [3:0] i_Key,
    input  logic       i_Valid,
    output logic       o_Ready,
    output logic [3:0] o_Col,
    output logic       o_KeyDown,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam int GAP_EFF  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_EFF - 1);
    localparam logic             GAP_ONE   = (GAP_EFF == 1);

`ifdef KEYPAD_BOUNCE_EN
    localparam int BP_EFF = (BOUNCE_PERIOD == 0) ? 1 : BOUNCE_PERIOD;
    localparam logic [CNT_W-1:0] BP_LOAD = CNT_W'(BP_EFF - 1);
    localparam int PH_W = (BOUNCE_NUM > 0) ? $clog2(2 * BOUNCE_NUM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * BOUNCE_NUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRESS_B, S_HOLD, S_REL_B, S_GAP} state_t;
    logic [PH_W-1:0] phase;
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       key;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            key       <= 4'h0;
            o_KeyDown <= 1'b0;
            o_Ready   <= 1'b1;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
            phase     <= '0;
`endif
        end else begin
            o_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_Valid) begin
                        key       <= i_Key;
                        o_Ready   <= 1'b0;
                        o_Busy    <= 1'b1;
                        o_KeyDown <= 1'b1;
`ifdef KEYPAD_BOUNCE_EN
                        phase     <= '0;
                        if (BOUNCE_NUM > 0) begin
                            state <= S_PRESS_B;
                            cnt   <= BP_LOAD;
                        end else begin
                            state <= S_HOLD;
                            cnt   <= HOLD_LOAD;
                        end
`else
                        state     <= S_HOLD;
                        cnt       <= HOLD_LOAD;
`endif
                    end
                end
`ifdef KEYPAD_BOUNCE_EN
                // Even phases match the burst's leading level: closed on press, open on release.
                S_PRESS_B: begin
                    if (cnt == '0) begin
                        if (phase == PH_LAST) begin
                            state     <= S_HOLD;
                            cnt       <= HOLD_LOAD;
                            o_KeyDown <= 1'b1;
                        end else begin
                            phase     <= phase + 1'b1;
                            cnt       <= BP_LOAD;
                            o_KeyDown <= ~o_KeyDown;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_REL_B: begin
                    if (cnt == '0) begin
                        if (phase == PH_LAST) begin
                            state     <= S_GAP;
                            cnt       <= GAP_LOAD;
                            o_KeyDown <= 1'b0;
                            o_Done    <= GAP_ONE;
                        end else begin
                            phase     <= phase + 1'b1;
                            cnt       <= BP_LOAD;
                            o_KeyDown <= ~o_KeyDown;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                S_HOLD: begin
                    if (cnt == '0) begin
                        o_KeyDown <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
                        phase     <= '0;
                        if (BOUNCE_NUM > 0) begin
                            state <= S_REL_B;
                            cnt   <= BP_LOAD;
                        end else begin
                            state  <= S_GAP;
                            cnt    <= GAP_LOAD;
                            o_Done <= GAP_ONE;
                        end
`else
                        state     <= S_GAP;
                        cnt       <= GAP_LOAD;
                        o_Done    <= GAP_ONE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state   <= S_IDLE;
                        o_Ready <= 1'b1;
                        o_Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        // Flag the final gap cycle one edge early so o_Done stays registered.
                        o_Done <= (cnt == CNT_W'(1));
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_Col = 4'b1111;
        if (o_KeyDown && !i_Row[key[3:2]]) begin
            o_Col[key[1:0]] = 1'b0;
        end
    end

endmodule
